// File: rtl/axis_eth_tx_pad.sv
// AXI-Stream byte-wide Ethernet TX padder: short frames are extended with zero bytes up to
// MIN_FRAME_LENGTH, and the frame's tuser is moved onto the final pad beat.
module axis_eth_tx_pad #(
    parameter int unsigned MIN_FRAME_LENGTH = 60,
    parameter int unsigned USER_WIDTH       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_padded,
    output logic                  status_frame
);

    typedef enum logic [0:0] {StPass, StPad} state_e;

    localparam logic [16:0] MinLen = 17'(MIN_FRAME_LENGTH);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [USER_WIDTH-1:0] user_cap_q, user_cap_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  padded_q, padded_d;

    logic        load;
    logic [15:0] cnt_inc;
    logic        at_min;

    assign load    = !valid_q || m_axis_tready;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // 17-bit compare so a saturated counter still counts as long enough
    assign at_min  = ({1'b0, cnt_q} + 17'd1) >= MinLen;

    assign s_axis_tready = rst_n && (state_q == StPass) && load;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        user_cap_d = user_cap_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        user_d     = user_q;
        padded_d   = padded_q;

        if (load) begin
            unique case (state_q)
                StPass: begin
                    if (s_axis_tvalid) begin
                        valid_d  = 1'b1;
                        data_d   = s_axis_tdata;
                        last_d   = 1'b0;
                        user_d   = '0;
                        padded_d = 1'b0;
                        cnt_d    = cnt_inc;
                        if (s_axis_tlast) begin
                            if (at_min) begin
                                last_d = 1'b1;
                                user_d = s_axis_tuser;
                                cnt_d  = '0;
                            end else begin
                                user_cap_d = s_axis_tuser;
                                state_d    = StPad;
                            end
                        end
                    end else begin
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                        user_d   = '0;
                        padded_d = 1'b0;
                    end
                end
                StPad: begin
                    valid_d = 1'b1;
                    data_d  = 8'h00;
                    if (at_min) begin
                        last_d     = 1'b1;
                        user_d     = user_cap_q;
                        padded_d   = 1'b1;
                        cnt_d      = '0;
                        user_cap_d = '0;
                        state_d    = StPass;
                    end else begin
                        last_d   = 1'b0;
                        user_d   = '0;
                        padded_d = 1'b0;
                        cnt_d    = cnt_inc;
                    end
                end
                default: state_d = StPass;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StPass;
            cnt_q      <= '0;
            user_cap_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            user_q     <= '0;
            padded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            user_cap_q <= user_cap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            user_q     <= user_d;
            padded_q   <= padded_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign status_frame  = valid_q && m_axis_tready && last_q;
    assign status_padded = status_frame && padded_q;

endmodule
